booth_algo: RTL and testbench
=============================

# booth_algo

One radix-2 Booth step, built as a registered pipeline stage inside the floating-point mantissa multiplier (float_mul_nb).
- A chain of WIDTH instances with BSTEP = 0..WIDTH-1, plus a final add-and-shift downstream, yields the high WIDTH+2-bit half of the signed product (multiplicand × multiplier) / 2^WIDTH, floored.
- Each stage completes the previous step's pending addition, shifts the accumulator, and emits the next partial product.
- The operands travel alongside the accumulator.

## Interface
- WIDTH, default 8: operand width in bits (two's complement).
- BSTEP, default 0: index of the multiplier bit this stage examines, 0..WIDTH-1.

Ports:
- clk  in  1: clock, rising edge.
- nrst  in  1: synchronous, active-low reset.
- din_multiplicand  in  WIDTH: multiplicand M, signed.
- din_multilplier  in  WIDTH: multiplier Q, signed. Port name is spelled exactly this way.
- din_addend  in  WIDTH+2: accumulator from the previous stage, signed.
- din_augend  in  WIDTH+2: pending partial product from the previous stage, signed.
- din_valid  in  1: input data valid.
- dout_multiplicand  out  WIDTH: registered copy of M.
- dout_multilplier  out  WIDTH: registered copy of Q.
- dout_addend  out  WIDTH+2: updated accumulator.
- dout_augend  out  WIDTH+2: this stage's partial product.
- dout_valid  out  1: output valid.

## Operation
- Sum: s = din_addend + din_augend, computed in WIDTH+2 bits, wrapping.
- Accumulator:
  - BSTEP = 0: a = s, unshifted. din_addend may therefore carry an initial accumulator value; it is normally 0.
  - BSTEP > 0: a = s >>> 1, arithmetic shift. The LSB is discarded, i.e. truncation.
- Booth digit: d = Q[BSTEP-1] − Q[BSTEP], with Q[-1] = 0 for BSTEP = 0.
- Partial product p, in WIDTH+2 bits:
  - d = +1: sign-extended M.
  - d = −1: two's-complement negation of sign-extended M. Negating M = −2^(WIDTH-1) gives +2^(WIDTH-1), which fits.
  - d = 0: 0.
- Range: |a| ≤ 2^(WIDTH-1) and |p| ≤ 2^(WIDTH-1), so no overflow occurs in WIDTH+2 bits for a zero-initialised chain.
- Chain result: after stage WIDTH-1, floor(M·Q / 2^WIDTH) = (dout_addend + dout_augend) >>> 1. This final add-and-shift is done downstream, not in this block. Low product bits are not produced.
- The block is purely combinational into one register bank. No FSM, no backpressure.

## Timing
- Latency is 1 cycle: inputs sampled at edge n appear on the outputs after edge n.
- Throughput is one operation per cycle.
- nrst = 0 at a rising edge: all outputs become 0 (data and dout_valid). Reset overrides din_valid, including mid-stream; in-flight data is dropped.
- nrst = 1 and din_valid = 1: all data registers load the new values and dout_valid ← 1.
- nrst = 1 and din_valid = 0: data registers hold their previous values and dout_valid ← 0.
- dout_valid always follows din_valid with one cycle of delay, regardless of the data values.

## Test plan
- Reset: nrst = 0 for 2 cycles with din_valid = 1 and nonzero data.
  - Required: every output is 0 after the first edge.
  - Release nrst: outputs update on the next valid edge.
- BSTEP = 0 stage: M = 0x5E, Q = 0x6A, addend = augend = 0, valid = 1.
  - Required: dout_addend = 0x000, dout_augend = 0x000 (Q[0] = 0), M/Q passed through, dout_valid = 1 one cycle later.
- Single-digit checks, same operands: BSTEP = 1 gives d = −1, so dout_augend = 0x3A2 (−94). BSTEP = 2 gives d = +1, so dout_augend = 0x05E.
- Shift check, BSTEP = 3: addend = 0x3A2, augend = 0x05E.
  - Required: dout_addend = 0x000 (s = 0, shifted).
  - addend = 0x001, augend = 0x002: dout_addend = 0x001.
  - addend = 0x3FD (−3), augend = 0: dout_addend = 0x3FE (floor).
- Full 8-stage chain, with a model doing the final (addend + augend) >>> 1:
  - 0x5E × 0x6A → 0x026 (9964 >> 8 = 38).
  - 0x80 × 0x80 → 0x040.
  - 0xFF × 0x01 → 0x3FF (−1).
  - Random signed pairs must match floor(M·Q / 256), with results emerging 8 cycles after input.
- Valid gating: alternate din_valid 1/0 while changing data.
  - Required: outputs hold during invalid cycles.
  - dout_valid pattern equals the din_valid pattern delayed by 1 cycle.
  - Asserting nrst = 0 mid-burst clears dout_valid on the next edge.

Source files
------------

// File: rtl/booth_algo.sv
// booth_algo: one registered radix-2 Booth step; finishes the previous add, shifts, emits the next partial product
module booth_algo #(
  parameter int WIDTH = 8,
  parameter int BSTEP = 0
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [WIDTH-1:0] din_multiplicand,
  input  logic [WIDTH-1:0] din_multilplier,
  input  logic [WIDTH+1:0] din_addend,
  input  logic [WIDTH+1:0] din_augend,
  input  logic             din_valid,
  output logic [WIDTH-1:0] dout_multiplicand,
  output logic [WIDTH-1:0] dout_multilplier,
  output logic [WIDTH+1:0] dout_addend,
  output logic [WIDTH+1:0] dout_augend,
  output logic             dout_valid
);
  logic signed [WIDTH+1:0] sum, acc, m_ext, pp;
  logic                    q_cur, q_prev;
  logic [WIDTH-1:0]        mcand_d, mcand_q, mplier_d, mplier_q;
  logic [WIDTH+1:0]        addend_d, addend_q, augend_d, augend_q;
  logic                    valid_d, valid_q;
  always_comb begin
    sum      = din_addend + din_augend;
    acc      = (BSTEP == 0) ? sum : sum >>> 1;
    m_ext    = {{2{din_multiplicand[WIDTH-1]}}, din_multiplicand};
    q_cur    = din_multilplier[BSTEP];
    q_prev   = (BSTEP == 0) ? 1'b0 : din_multilplier[(BSTEP == 0) ? 0 : BSTEP - 1];
    pp       = (q_prev & ~q_cur) ? m_ext : (~q_prev & q_cur) ? -m_ext : '0;
    valid_d  = din_valid;
    mcand_d  = din_valid ? din_multiplicand : mcand_q;
    mplier_d = din_valid ? din_multilplier : mplier_q;
    addend_d = din_valid ? $unsigned(acc) : addend_q;
    augend_d = din_valid ? $unsigned(pp) : augend_q;
  end
  always_ff @(posedge clk) begin
    if (!nrst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      addend_q <= '0;
      augend_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      addend_q <= addend_d;
      augend_q <= augend_d;
      valid_q  <= valid_d;
    end
  end
  assign dout_multiplicand = mcand_q;
  assign dout_multilplier  = mplier_q;
  assign dout_addend       = addend_q;
  assign dout_augend       = augend_q;
  assign dout_valid        = valid_q;
endmodule

// File: tb/tb_booth_algo.sv
// tb_booth_algo: directed single-stage vectors, an 8-stage chain against a product model, valid gating and reset
module tb_booth_algo;
  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] m, q;
  logic [9:0] add, aug;
  logic       vld;
  logic [7:0] o_m[4], o_q[4];
  logic [9:0] o_add[4], o_aug[4];
  logic       o_v[4];

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_single
      booth_algo #(.WIDTH(8), .BSTEP(g)) u_stage (
        .clk(clk), .nrst(nrst),
        .din_multiplicand(m), .din_multilplier(q),
        .din_addend(add), .din_augend(aug), .din_valid(vld),
        .dout_multiplicand(o_m[g]), .dout_multilplier(o_q[g]),
        .dout_addend(o_add[g]), .dout_augend(o_aug[g]), .dout_valid(o_v[g])
      );
    end
  endgenerate

  logic [7:0] ch_m, ch_q;
  logic       ch_v;
  logic [7:0] c_m[9], c_q[9];
  logic [9:0] c_add[9], c_aug[9];
  logic       c_v[9];
  assign c_m[0]   = ch_m;
  assign c_q[0]   = ch_q;
  assign c_add[0] = '0;
  assign c_aug[0] = '0;
  assign c_v[0]   = ch_v;

  generate
    for (g = 0; g < 8; g++) begin : g_chain
      booth_algo #(.WIDTH(8), .BSTEP(g)) u_stage (
        .clk(clk), .nrst(nrst),
        .din_multiplicand(c_m[g]), .din_multilplier(c_q[g]),
        .din_addend(c_add[g]), .din_augend(c_aug[g]), .din_valid(c_v[g]),
        .dout_multiplicand(c_m[g+1]), .dout_multilplier(c_q[g+1]),
        .dout_addend(c_add[g+1]), .dout_augend(c_aug[g+1]), .dout_valid(c_v[g+1])
      );
    end
  endgenerate

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    int         sel;
    logic [7:0] m, q;
    logic [9:0] add, aug, e_add, e_aug;
  } vec_t;
  vec_t tv[9];

  typedef struct {
    logic [9:0] e;
    int         t;
  } exp_t;
  exp_t sb[$];

  logic [7:0]        dm[3] = '{8'h5E, 8'h80, 8'hFF};
  logic [7:0]        dq[3] = '{8'h6A, 8'h80, 8'h01};
  logic signed [7:0] ra, rb;
  logic signed [9:0] s10;
  logic [9:0]        res;
  logic [7:0]        hm, hq;
  logic              pv;
  exp_t              ent;
  int                idx;

  initial begin
    tv[0] = '{0, 8'h5E, 8'h6A, 10'h000, 10'h000, 10'h000, 10'h000};
    tv[1] = '{1, 8'h5E, 8'h6A, 10'h000, 10'h000, 10'h000, 10'h3A2};
    tv[2] = '{2, 8'h5E, 8'h6A, 10'h000, 10'h000, 10'h000, 10'h05E};
    tv[3] = '{3, 8'h5E, 8'h6A, 10'h3A2, 10'h05E, 10'h000, 10'h3A2};
    tv[4] = '{3, 8'h5E, 8'h6A, 10'h001, 10'h002, 10'h001, 10'h3A2};
    tv[5] = '{3, 8'h5E, 8'h6A, 10'h3FD, 10'h000, 10'h3FE, 10'h3A2};
    tv[6] = '{0, 8'h80, 8'h01, 10'h005, 10'h001, 10'h006, 10'h080};
    tv[7] = '{1, 8'h80, 8'h01, 10'h3FF, 10'h3FF, 10'h3FF, 10'h380};
    tv[8] = '{2, 8'hFF, 8'h02, 10'h1FF, 10'h001, 10'h300, 10'h3FF};

    // reset held with valid data on the inputs
    nrst = 1'b0; vld = 1'b1; m = 8'hA5; q = 8'h3C; add = 10'h155; aug = 10'h2AA;
    ch_v = 1'b1; ch_m = 8'h77; ch_q = 8'h99;
    repeat (2) begin
      @(posedge clk); #1;
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("rst_m%0d", k), 32'(o_m[k]), 0);
        chk($sformatf("rst_q%0d", k), 32'(o_q[k]), 0);
        chk($sformatf("rst_add%0d", k), 32'(o_add[k]), 0);
        chk($sformatf("rst_aug%0d", k), 32'(o_aug[k]), 0);
        chk($sformatf("rst_v%0d", k), 32'(o_v[k]), 0);
      end
      chk("rst_chain_v", 32'(c_v[1]), 0);
    end
    nrst = 1'b1; ch_v = 1'b0;

    for (int i = 0; i < 9; i++) begin
      m = tv[i].m; q = tv[i].q; add = tv[i].add; aug = tv[i].aug; vld = 1'b1;
      @(posedge clk); #1;
      chk($sformatf("v%0d_add", i), 32'(o_add[tv[i].sel]), 32'(tv[i].e_add));
      chk($sformatf("v%0d_aug", i), 32'(o_aug[tv[i].sel]), 32'(tv[i].e_aug));
      chk($sformatf("v%0d_m", i), 32'(o_m[tv[i].sel]), 32'(tv[i].m));
      chk($sformatf("v%0d_q", i), 32'(o_q[tv[i].sel]), 32'(tv[i].q));
      chk($sformatf("v%0d_v", i), 32'(o_v[tv[i].sel]), 1);
    end

    // valid gating on the BSTEP=2 stage: registers hold while din_valid is low
    hm = o_m[2]; hq = o_q[2]; pv = 1'b1;
    for (int i = 0; i < 12; i++) begin
      vld = (i % 3) != 1 && (i % 5) != 2;
      m = 8'(i * 37 + 5); q = 8'(i * 11 + 3); add = '0; aug = '0;
      if (vld) begin hm = m; hq = q; end
      @(posedge clk); #1;
      chk($sformatf("gate%0d_v", i), 32'(o_v[2]), 32'(vld));
      chk($sformatf("gate%0d_m", i), 32'(o_m[2]), 32'(hm));
      chk($sformatf("gate%0d_q", i), 32'(o_q[2]), 32'(hq));
      pv = vld;
    end
    vld = 1'b1; m = 8'h11; q = 8'h22;
    @(posedge clk); #1;
    chk("burst_v_pre", 32'(o_v[2]), 1);
    nrst = 1'b0;
    @(posedge clk); #1;
    chk("burst_rst_v", 32'(o_v[2]), 0);
    chk("burst_rst_m", 32'(o_m[2]), 0);
    nrst = 1'b1; vld = 1'b0;

    // full 8-stage chain: directed then random operands, with periodic bubbles
    idx = 0;
    for (int t = 0; t < 80; t++) begin
      if (idx < 23 && (t % 5) != 4) begin
        if (idx < 3) begin ra = dm[idx]; rb = dq[idx]; end
        else begin ra = 8'($urandom); rb = 8'($urandom); end
        ch_m = ra; ch_q = rb; ch_v = 1'b1;
        sb.push_back('{10'((int'(ra) * int'(rb)) >>> 8), t});
        idx++;
      end else begin
        ch_v = 1'b0; ch_m = 8'($urandom); ch_q = 8'($urandom);
      end
      @(posedge clk); #1;
      if (c_v[8]) begin
        if (sb.size() == 0) chk("chain_spurious_valid", 1, 0);
        else begin
          ent = sb.pop_front();
          s10 = c_add[8] + c_aug[8];
          res = s10 >>> 1;
          chk($sformatf("chain_res_t%0d", ent.t), 32'(res), 32'(ent.e));
          chk($sformatf("chain_lat_t%0d", ent.t), 32'(t - ent.t + 1), 8);
        end
      end
    end
    chk("chain_pending", 32'(sb.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
